prefetcher_stream_ctrl: RTL

//  Multi-stream stride-learning prefetch controller; successor to single-slice prefetcher control.

---
 rtl/prefetcher_stream_ctrl_pkg.sv | 54 +++++
 rtl/prefetcher_stream_ctrl_if.sv | 37 +++
 rtl/prefetcher_stream_ctrl_ctx.sv | 134 +++++++++++++
 rtl/prefetcher_stream_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/prefetcher_stream_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : prefetcher_stream_pkg
// Brief    : Shared widths, types and helpers for the stream prefetch controller
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package prefetcher_stream_pkg;

  localparam int ADDR_BITS   = 64;
  localparam int OFFSET_BITS = 6;
  localparam int TID_WIDTH   = 8;
  localparam int LEN_WIDTH   = 8;
  localparam int NUM_STREAMS = 4;
  localparam int CONF_WIDTH  = 2;
  localparam int OUTST_WIDTH = 4;
  localparam int IDLE_WIDTH  = 10;
  localparam int GAP_WIDTH   = 6;
  localparam int IDX_WIDTH   = $clog2(NUM_STREAMS);

  typedef logic [ADDR_BITS-1:0]   addr_t;
  typedef logic [TID_WIDTH-1:0]   tid_t;
  typedef logic [LEN_WIDTH-1:0]   len_t;
  typedef logic [CONF_WIDTH-1:0]  conf_t;
  typedef logic [OUTST_WIDTH-1:0] outst_t;
  typedef logic [IDLE_WIDTH-1:0]  idle_t;
  typedef logic [IDX_WIDTH-1:0]   idx_t;
  typedef logic [GAP_WIDTH-1:0]   gap_t;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_ARMED   = 2'd2,
    ST_ACTIVE  = 2'd3
  } stream_state_e;

  typedef struct packed {
    tid_t          id;
    len_t          len;
    addr_t         last;
    addr_t         stride;
    addr_t         next_pf;
    conf_t         conf;
    stream_state_e state;
  } stream_ctx_t;

  // Clears the cacheline offset bits of an address
  localparam addr_t c_line_mask = {{(ADDR_BITS-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  function automatic addr_t line_align(input addr_t a);
    return a & c_line_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetcher_stream_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : prefetcher_stream_ctrl_if
// Brief    : Demand snoop, prefetch request and retire buses of the controller
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface prefetcher_stream_ctrl_if;
  import prefetcher_stream_pkg::*;

  logic  d_valid;
  addr_t d_addr;
  tid_t  d_id;
  len_t  d_len;

  logic  pf_valid;
  logic  pf_ready;
  addr_t pf_addr;
  tid_t  pf_id;
  len_t  pf_len;
  idx_t  pf_stream;

  logic  done_valid;
  idx_t  done_stream;

  // Environment side: snoop source, prefetch datapath and retire reporter
  modport master (
    output d_valid, d_addr, d_id, d_len, pf_ready, done_valid, done_stream,
    input  pf_valid, pf_addr, pf_id, pf_len, pf_stream
  );

  // Controller side
  modport slave (
    input  d_valid, d_addr, d_id, d_len, pf_ready, done_valid, done_stream,
    output pf_valid, pf_addr, pf_id, pf_len, pf_stream
  );
endinterface
`default_nettype wire

// File: rtl/prefetcher_stream_ctrl_ctx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pf_stream_ctx
// Brief    : One stream context: training FSM, confidence, idle and
//            outstanding-prefetch counters
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pf_stream_ctx
  import prefetcher_stream_pkg::*;
#(
  parameter int CONF_THRESH = 2
) (
  input  wire logic        clk,
  input  wire logic        resetN,
  input  wire logic        i_flush,
  input  wire logic        i_alloc,
  input  wire logic        i_hit,
  input  wire addr_t       i_addr,
  input  wire tid_t        i_id,
  input  wire len_t        i_len,
  input  wire logic        i_accept,
  input  wire logic        i_done,
  input  wire idle_t       i_idle_limit,
  output stream_ctx_t      o_ctx,
  output outst_t           o_outst
);

  localparam conf_t c_thresh = conf_t'(CONF_THRESH);

  stream_ctx_t r_ctx;
  stream_ctx_t w_nxt;
  idle_t       r_idle;
  idle_t       w_nxt_idle;
  outst_t      r_outst;
  addr_t       w_sample;
  conf_t       w_conf_inc;

  // Next-state: flush beats allocation beats demand hit beats idle ageing
  always_comb begin
    w_nxt      = r_ctx;
    w_nxt_idle = r_idle;
    w_sample   = i_addr - r_ctx.last;
    w_conf_inc = (r_ctx.conf == '1) ? r_ctx.conf : r_ctx.conf + conf_t'(1);
    // An accepted request advances the prefetch pointer; a hit below may resync it
    if (i_accept) begin
      w_nxt.next_pf = r_ctx.next_pf + r_ctx.stride;
    end
    if (i_flush) begin
      w_nxt.state = ST_INVALID;
    end else if (i_alloc) begin
      w_nxt.id    = i_id;
      w_nxt.len   = i_len;
      w_nxt.last  = i_addr;
      w_nxt.conf  = '0;
      w_nxt.state = ST_TRAIN;
      w_nxt_idle  = '0;
    end else if (i_hit) begin
      w_nxt.last = i_addr;
      w_nxt_idle = '0;
      if (i_len != r_ctx.len) begin
        w_nxt.len   = i_len;
        w_nxt.conf  = '0;
        w_nxt.state = ST_TRAIN;
      end else if (w_sample != '0) begin
        case (r_ctx.state)
          ST_TRAIN: begin
            w_nxt.stride = w_sample;
            w_nxt.conf   = conf_t'(1);
            if (CONF_THRESH == 1) begin
              w_nxt.state   = ST_ACTIVE;
              w_nxt.next_pf = i_addr + w_sample;
            end else begin
              w_nxt.state = ST_ARMED;
            end
          end
          ST_ARMED, ST_ACTIVE: begin
            if (w_sample == r_ctx.stride) begin
              w_nxt.conf = w_conf_inc;
              if (r_ctx.state == ST_ARMED && w_conf_inc >= c_thresh) begin
                w_nxt.state   = ST_ACTIVE;
                w_nxt.next_pf = i_addr + r_ctx.stride;
              end
            end else if (r_ctx.conf <= conf_t'(1)) begin
              // Confidence exhausted: adopt the new stride and re-arm
              w_nxt.stride = w_sample;
              w_nxt.conf   = conf_t'(1);
              w_nxt.state  = ST_ARMED;
            end else begin
              w_nxt.conf = r_ctx.conf - conf_t'(1);
            end
          end
          default: ;
        endcase
        // Nothing in flight: restart prefetching just ahead of the demand
        if (r_ctx.state == ST_ACTIVE && w_nxt.state == ST_ACTIVE && r_outst == '0) begin
          w_nxt.next_pf = i_addr + w_nxt.stride;
        end
      end
    end else if (r_ctx.state != ST_INVALID) begin
      if (i_idle_limit != '0 && r_idle >= i_idle_limit) begin
        w_nxt.state = ST_INVALID;
      end else if (r_idle != '1) begin
        w_nxt_idle = r_idle + idle_t'(1);
      end
    end
  end

  // Context and idle counter registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ctx  <= '0;
      r_idle <= '0;
    end else begin
      r_ctx  <= w_nxt;
      r_idle <= w_nxt_idle;
    end
  end

  // Outstanding prefetches: +1 on accept, -1 on retire, simultaneous events cancel
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_outst <= '0;
    end else if (i_accept && !i_done) begin
      if (r_outst != '1) r_outst <= r_outst + outst_t'(1);
    end else if (i_done && !i_accept) begin
      if (r_outst != '0) r_outst <= r_outst - outst_t'(1);
    end
  end

  assign o_ctx   = r_ctx;
  assign o_outst = r_outst;

endmodule
`default_nettype wire

// File: rtl/prefetcher_stream_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : prefetcher_stream_ctrl
// Brief    : Multi-stream stride-learning prefetch controller: demand lookup,
//            context allocation, round-robin issue with gap control
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module prefetcher_stream_ctrl
  import prefetcher_stream_pkg::*;
#(
  parameter int CONF_THRESH = 2
) (
  input  wire logic                   clk,
  input  wire logic                   resetN,
  input  wire logic                   ctrlFlush,
  prefetcher_stream_ctrl_if.slave     bus,
  input  wire addr_t                  crs_bar,
  input  wire addr_t                  crs_limit,
  input  wire outst_t                 crs_outstLimit,
  input  wire gap_t                   crs_issueGap,
  input  wire idle_t                  crs_idleLimit,
  output logic [NUM_STREAMS-1:0]      active_mask
);

  stream_ctx_t            w_ctx       [NUM_STREAMS];
  outst_t                 w_outst     [NUM_STREAMS];
  addr_t                  w_eff_next  [NUM_STREAMS];
  logic [OUTST_WIDTH:0]   w_eff_outst [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] w_valid, w_hit, w_alloc, w_elig, w_acc, w_done;
  logic                   w_learn, w_miss, w_free_found, w_sel_found;
  logic                   w_accept, w_gap_ok, w_load;
  idx_t                   w_free_idx, w_sel_idx, w_cand;
  addr_t                  w_daddr;

  idx_t  r_victim;
  idx_t  r_last_grant;
  gap_t  r_gap;
  logic  r_pf_valid;
  addr_t r_pf_addr;
  tid_t  r_pf_id;
  len_t  r_pf_len;
  idx_t  r_pf_stream;

  assign w_daddr  = line_align(bus.d_addr);
  assign w_learn  = bus.d_valid && !ctrlFlush;
  assign w_accept = r_pf_valid && bus.pf_ready;

  // ID lookup and allocation target (lowest free entry, else victim pointer)
  always_comb begin
    w_valid      = '0;
    w_hit        = '0;
    w_alloc      = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      w_valid[i] = (w_ctx[i].state != ST_INVALID);
      w_hit[i]   = w_learn && w_valid[i] && (w_ctx[i].id == bus.d_id);
    end
    for (int i = NUM_STREAMS-1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = idx_t'(i);
      end
    end
    w_miss = w_learn && (w_hit == '0);
    if (w_miss) begin
      if (w_free_found) w_alloc[w_free_idx] = 1'b1;
      else              w_alloc[r_victim]   = 1'b1;
    end
  end

  // Eligibility, using post-accept pointer/count for the stream retiring this cycle
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      w_eff_next[i]  = w_ctx[i].next_pf + (w_acc[i] ? w_ctx[i].stride : '0);
      w_eff_outst[i] = {1'b0, w_outst[i]} + {{OUTST_WIDTH{1'b0}}, w_acc[i]};
      w_elig[i] = (w_ctx[i].state == ST_ACTIVE) && !ctrlFlush && !w_hit[i] && !w_alloc[i]
                  && (w_eff_outst[i] < {1'b0, crs_outstLimit})
                  && (w_eff_next[i] >= crs_bar) && (w_eff_next[i] <= crs_limit);
    end
  end

  // Round-robin pick starting just after the last granted stream
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      w_cand = r_last_grant + idx_t'(k);
      if (!w_sel_found && w_elig[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  // The cycle of selection counts as idle, so the loaded request lands exactly
  // crs_issueGap cycles after the previous acceptance
  assign w_gap_ok = w_accept ? (crs_issueGap == '0)
                             : (({1'b0, r_gap} + 7'd1) >= {1'b0, crs_issueGap});
  assign w_load   = (!r_pf_valid || bus.pf_ready) && w_gap_ok && w_sel_found;

  // Output request register: payload frozen until accepted
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pf_valid   <= 1'b0;
      r_pf_addr    <= '0;
      r_pf_id      <= '0;
      r_pf_len     <= '0;
      r_pf_stream  <= '0;
      r_last_grant <= '1;
    end else if (w_load) begin
      r_pf_valid   <= 1'b1;
      r_pf_addr    <= w_eff_next[w_sel_idx];
      r_pf_id      <= w_ctx[w_sel_idx].id;
      r_pf_len     <= w_ctx[w_sel_idx].len;
      r_pf_stream  <= w_sel_idx;
      r_last_grant <= w_sel_idx;
    end else if (w_accept) begin
      r_pf_valid   <= 1'b0;
    end
  end

  // Cycles since the last accepted prefetch, saturating
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)             r_gap <= '0;
    else if (w_accept)       r_gap <= '0;
    else if (r_gap != '1)    r_gap <= r_gap + gap_t'(1);
  end

  // Victim pointer advances only when an occupied entry is replaced
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                        r_victim <= '0;
    else if (ctrlFlush)                 r_victim <= '0;
    else if (w_miss && !w_free_found)   r_victim <= r_victim + idx_t'(1);
  end

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_ctx
    assign w_acc[g]       = w_accept && (r_pf_stream == idx_t'(g));
    assign w_done[g]      = bus.done_valid && (bus.done_stream == idx_t'(g));
    assign active_mask[g] = (w_ctx[g].state == ST_ACTIVE);

    pf_stream_ctx #(.CONF_THRESH(CONF_THRESH)) u_ctx (
      .clk          (clk),
      .resetN       (resetN),
      .i_flush      (ctrlFlush),
      .i_alloc      (w_alloc[g]),
      .i_hit        (w_hit[g]),
      .i_addr       (w_daddr),
      .i_id         (bus.d_id),
      .i_len        (bus.d_len),
      .i_accept     (w_acc[g]),
      .i_done       (w_done[g]),
      .i_idle_limit (crs_idleLimit),
      .o_ctx        (w_ctx[g]),
      .o_outst      (w_outst[g])
    );
  end

  assign bus.pf_valid  = r_pf_valid;
  assign bus.pf_addr   = r_pf_addr;
  assign bus.pf_id     = r_pf_id;
  assign bus.pf_len    = r_pf_len;
  assign bus.pf_stream = r_pf_stream;

endmodule
`default_nettype wire
